rsa256_uart_wrapper: RTL and testbench

- Host-side controller that drives the 256-bit RSA decryption core from a byte stream on an RS-232 UART.
- Acts as an Avalon-MM master polling the UART status register.
- Receives modulus n and private key d once, then loops on 32-byte ciphertext blocks.
- Starts the core for each block and returns the plaintext bytes over the same UART.

---
 rtl/rsa256_uart_wrapper.sv | 94 +++++++++
 tb/tb_rsa256_uart_wrapper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa256_uart_wrapper.sv
// rsa256_uart_wrapper: UART-fed host controller for the 256-bit RSA core; define RSA_TX_FULL_WIDTH_EN to return all 32 result bytes
module rsa256_uart_wrapper #(
  parameter int RX_ADDR = 0,
  parameter int TX_ADDR = 4,
  parameter int STATUS_ADDR = 8,
  parameter int RX_OK_BIT = 7,
  parameter int TX_OK_BIT = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [4:0]   o_avm_address,
  output logic         o_avm_read,
  input  logic [31:0]  i_avm_readdata,
  output logic         o_avm_write,
  output logic [31:0]  o_avm_writedata,
  input  logic         i_avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished
);
  typedef enum logic [1:0] {S_GET_KEY, S_GET_DATA, S_WAIT_CALC, S_SEND_DATA} state_t;
`ifdef RSA_TX_FULL_WIDTH_EN
  localparam logic [6:0] TX_LAST = 7'd31;
  logic [255:0] out_load;
  logic unused_bits;
  assign out_load = i_core_a_pow_d;
  assign unused_bits = ^i_avm_readdata[31:8];
`else
  localparam logic [6:0] TX_LAST = 7'd30;
  logic [255:0] out_load;
  logic unused_bits;
  assign out_load = {i_core_a_pow_d[247:0], 8'd0};
  assign unused_bits = ^{i_avm_readdata[31:8], i_core_a_pow_d[255:248]};
`endif
  state_t state, state_nxt;
  logic [6:0] cnt, last;
  logic phase, quiet, done, data_done, ok, issue;
  logic [255:0] n_r, d_r, a_r, out_r;
  assign done = (o_avm_read | o_avm_write) & ~i_avm_waitrequest;
  assign data_done = done & phase;
  assign ok = i_avm_readdata[state == S_SEND_DATA ? TX_OK_BIT : RX_OK_BIT];
  assign last = state == S_GET_KEY ? 7'd63 : state == S_GET_DATA ? 7'd31 : TX_LAST;
  assign issue = ~(o_avm_read | o_avm_write) & quiet & (state != S_WAIT_CALC | i_core_finished);
  assign o_avm_writedata = {24'd0, out_r[255:248]};
  assign o_core_a = a_r;
  assign o_core_d = d_r;
  assign o_core_n = n_r;
  // next state: advance after the last data byte of a phase or on core completion
  always_comb begin
    state_nxt = state;
    if (state == S_WAIT_CALC)
      state_nxt = i_core_finished ? S_SEND_DATA : state;
    else if (data_done && cnt == last)
      state_nxt = state == S_GET_KEY ? S_GET_DATA : state == S_GET_DATA ? S_WAIT_CALC : S_GET_DATA;
  end
  // state register, Avalon request sequencing and byte shift registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_GET_KEY;
      cnt <= 7'd0;
      phase <= 1'b0;
      quiet <= 1'b1;
      o_avm_read <= 1'b0;
      o_avm_write <= 1'b0;
      o_avm_address <= 5'(STATUS_ADDR);
      o_core_start <= 1'b0;
      n_r <= '0;
      d_r <= '0;
      a_r <= '0;
      out_r <= '0;
    end else begin
      state <= state_nxt;
      cnt <= state_nxt != state ? 7'd0 : cnt + 7'(data_done);
      quiet <= ~(o_avm_read | o_avm_write);
      o_core_start <= state == S_GET_DATA && state_nxt == S_WAIT_CALC;
      if (done) begin
        phase <= ~phase & ok;
        o_avm_read <= 1'b0;
        o_avm_write <= 1'b0;
      end else if (issue) begin
        o_avm_read <= ~(phase & state == S_SEND_DATA);
        o_avm_write <= phase & state == S_SEND_DATA;
        o_avm_address <= ~phase ? 5'(STATUS_ADDR) : state == S_SEND_DATA ? 5'(TX_ADDR) : 5'(RX_ADDR);
      end
      if (data_done && state == S_GET_KEY && !cnt[5]) n_r <= {n_r[247:0], i_avm_readdata[7:0]};
      if (data_done && state == S_GET_KEY && cnt[5]) d_r <= {d_r[247:0], i_avm_readdata[7:0]};
      if (data_done && state == S_GET_DATA) a_r <= {a_r[247:0], i_avm_readdata[7:0]};
      out_r <= state == S_WAIT_CALC && i_core_finished ? out_load :
               data_done && state == S_SEND_DATA ? {out_r[247:0], 8'd0} : out_r;
    end
endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// tb_rsa256_uart_wrapper: directed bench with a UART register model and a stub RSA core
module tb_rsa256_uart_wrapper;
  localparam logic [255:0] N  = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
  localparam logic [255:0] D  = 256'h1F2E3D4C5B6A79880796A5B4C3D2E1F00F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [255:0] A  = 256'h0123456789ABCDEFFEDCBA98765432100011223344556677_8899AABBCCDDEEFF;
  localparam logic [255:0] A2 = 256'h5A5A5A5AA5A5A5A50F0F0F0FF0F0F0F0DEADBEEFCAFEBABE0102030405060708;
  localparam logic [255:0] R  = 256'h00ABCDEF123456789ABCDEF0112233445566778899AABBCCDDEEFF1020304001;
  localparam logic [255:0] R2 = 256'h00112233445566778899AABBCCDDEEFF0123456789ABCDEF0F1E2D3C4B5A6978;
`ifdef RSA_TX_FULL_WIDTH_EN
  localparam int NTX = 32;
`else
  localparam int NTX = 31;
`endif
  logic clk = 0, rst_n = 0;
  logic [4:0] address;
  logic rd, wr, start, wait_r = 0, fin = 0, tx_ok = 0, req_m, pr = 0, pw = 0;
  logic [31:0] rdata = 0, wdata, pd = 0;
  logic [4:0] pa = 0;
  logic [255:0] ca, cd, cn, res = 0;
  int vectors = 0, miscompares = 0;
  int poll_zero = 0, stall_cnt = 0, n_stall = 0, n_stat = 0, n_rx = 0, n_wr = 0, idle = 2;
  logic [7:0] rx_q[$];
  logic [7:0] wr_q[$];
  int seq[$];

  rsa256_uart_wrapper dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_avm_address(address), .o_avm_read(rd),
    .i_avm_readdata(rdata), .o_avm_write(wr), .o_avm_writedata(wdata),
    .i_avm_waitrequest(wait_r), .o_core_start(start), .o_core_a(ca), .o_core_d(cd),
    .o_core_n(cn), .i_core_a_pow_d(res), .i_core_finished(fin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push256(input logic [255:0] v);
    for (int i = 31; i >= 0; i--) rx_q.push_back(v[i*8+:8]);
  endtask

  // UART register model: responses change on the falling edge
  initial forever begin
    @(negedge clk);
    wait_r = wr && stall_cnt > 0;
    rdata = address == 5'd8 ? {24'd0, poll_zero == 0 && rx_q.size() != 0, tx_ok, 6'd0}
                            : {24'd0, rx_q.size() != 0 ? rx_q[0] : 8'd0};
  end

  // bus monitor: protocol rules and transfer log
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      idle = 2;
      pr = 0;
      pw = 0;
    end else begin
      req_m = rd | wr;
      if (req_m && !pr) begin
        chk("req_gap", idle >= 2, 1);
        chk("rw_excl", rd & wr, 0);
      end
      if (req_m && pr && pw) begin
        chk("hold_addr", address, pa);
        chk("hold_wdata", wdata, pd);
      end
      if (wr && wait_r) begin
        stall_cnt--;
        n_stall++;
      end
      if (req_m && !wait_r) begin
        if (wr) begin
          chk("wr_addr", address, 4);
          chk("wr_upper", wdata[31:8], 0);
          wr_q.push_back(wdata[7:0]);
          n_wr++;
          seq.push_back(36);
        end else if (address == 5'd8) begin
          n_stat++;
          if (poll_zero > 0) poll_zero--;
          seq.push_back(8);
        end else begin
          chk("rd_addr", address, 0);
          n_rx++;
          if (rx_q.size() != 0) void'(rx_q.pop_front());
          seq.push_back(0);
        end
      end
      idle = req_m ? 0 : (idle < 2 ? idle + 1 : 2);
      pr = req_m;
      pa = address;
      pd = wdata;
      pw = wait_r;
    end
  end

  initial begin
    int t, idx;
    repeat (3) cyc();
    chk("rst_addr", address, 8);
    chk("rst_read", rd, 0);
    chk("rst_write", wr, 0);
    chk("rst_start", start, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_n", cn, 0);
    chk("rst_d", cd, 0);
    chk("rst_a", ca, 0);
    poll_zero = 5;
    push256(N);
    push256(D);
    rst_n = 1;
    fin = 1;
    res = 256'hDEAD;
    cyc();
    fin = 0;
    res = 0;
    t = 0;
    while (n_rx < 1 && t < 500) begin cyc(); t++; end
    chk("first_rx", n_rx, 1);
    chk("poll_count", n_stat, 6);
    for (int i = 0; i < 6; i++) chk("poll_seq", seq[i], 8);
    chk("first_rx_seq", seq[6], 0);
    t = 0;
    while (n_rx < 64 && t < 5000) begin cyc(); t++; end
    chk("key_bytes", n_rx, 64);
    chk("key_n", cn, N);
    chk("key_d", cd, D);
    chk("a_idle", ca, 0);
    tx_ok = 1;
    push256(A);
    t = 0;
    while (!start && t < 2000) begin cyc(); t++; end
    chk("start_seen", start, 1);
    chk("rx_at_start", n_rx, 96);
    chk("a_at_start", ca, A);
    chk("n_at_start", cn, N);
    chk("d_at_start", cd, D);
    cyc();
    chk("start_width", start, 0);
    repeat (100) cyc();
    fin = 1;
    res = R;
    cyc();
    fin = 0;
    chk("tx_poll_read", rd, 1);
    chk("tx_poll_addr", address, 8);
    t = 0;
    while (n_wr < 4 && t < 1000) begin cyc(); t++; end
    chk("wr_before_stall", n_wr, 4);
    stall_cnt = 10;
    t = 0;
    while (n_wr < NTX && t < 5000) begin cyc(); t++; end
    chk("wr_count", n_wr, NTX);
    chk("stall_cycles", n_stall, 10);
    for (int i = 0; i < NTX; i++) chk("wr_byte", wr_q[i], R[(NTX-1-i)*8+:8]);
    idx = seq.size();
    t = 0;
    while (seq.size() <= idx && t < 200) begin cyc(); t++; end
    chk("resume_poll", seq[idx], 8);
    chk("no_key_reload", n_rx, 96);
    push256(A2);
    t = 0;
    while (!start && t < 2000) begin cyc(); t++; end
    chk("start2_seen", start, 1);
    chk("a2_at_start", ca, A2);
    chk("n_kept", cn, N);
    chk("d_kept", cd, D);
    repeat (20) cyc();
    fin = 1;
    res = R2;
    cyc();
    fin = 0;
    t = 0;
    while (n_wr < NTX + 10 && t < 2000) begin cyc(); t++; end
    chk("wr_before_rst", n_wr, NTX + 10);
    rst_n = 0;
    #1;
    chk("midrst_read", rd, 0);
    chk("midrst_write", wr, 0);
    chk("midrst_addr", address, 8);
    chk("midrst_n", cn, 0);
    chk("midrst_wdata", wdata, 0);
    cyc();
    cyc();
    idx = seq.size();
    push256(D);
    push256(N);
    rst_n = 1;
    t = 0;
    while (n_rx < 192 && t < 5000) begin cyc(); t++; end
    chk("reload_bytes", n_rx, 192);
    chk("reload_first_poll", seq[idx], 8);
    chk("reload_n", cn, D);
    chk("reload_d", cd, N);
    chk("no_wr_after_rst", n_wr, NTX + 10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
